// File: rtl/alu_pkg.sv
// Shared ALU definitions: op-code constants, result-entry layout and
// a helper that tells two-word results (MUL/DIV) from single-word ones.
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_ADD = 4'd6;
  localparam logic [3:0] OP_SUB = 4'd7;
  localparam logic [3:0] OP_SHL = 4'd8;
  localparam logic [3:0] OP_SHR = 4'd9;
  localparam logic [3:0] OP_MUL = 4'd10;
  localparam logic [3:0] OP_DIV = 4'd11;

  localparam int DATA_W  = 64;
  localparam int OP_W    = 4;
  localparam int ENTRY_W = DATA_W + OP_W;

  typedef struct packed {
    logic [OP_W-1:0] op;
    logic [31:0]     hi;
    logic [31:0]     lo;
  } z_entry_t;

  function automatic logic is_wide(
    input logic [OP_W-1:0] op
  );
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/z_fifo_mem.sv
// Result storage: DEPTH x 68-bit register array, one write port at the
// tail address and an asynchronous read of the head address.
// Ports: clk, we, waddr, wdata, raddr, rdata.
module z_fifo_mem
  import alu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  z_entry_t      wdata,
  input  logic [AW-1:0] raddr,
  output z_entry_t      rdata
);

  // contents are don't-care after reset, so no reset on the array
  z_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/z_result_stage.sv
// Z result stage: FIFO of ALU results (ZHI/ZLO + op) with valid/ready
// handshakes, bus word select and optional flags (macro Z_FLAGS_EN).
// Ports: clk, clr_n, c_lo_in, c_hi_in, op_in, in_valid, in_ready, flush,
//        out_valid, out_ready, sel_hi, sel_lo, bus_out, z_zero, z_neg,
//        count.
module z_result_stage
  import alu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   clr_n,
  input  logic [31:0]            c_lo_in,
  input  logic [31:0]            c_hi_in,
  input  logic [3:0]             op_in,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  input  logic                   sel_hi,
  input  logic                   sel_lo,
  output logic [31:0]            bus_out,
  output logic                   z_zero,
  output logic                   z_neg,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [AW-1:0] head_ptr;
  logic [AW-1:0] tail_ptr;
  logic          push;
  logic          pop;
  z_entry_t      wr_entry;
  z_entry_t      head;

  assign in_ready  = (count < FULL);
  assign out_valid = (count != '0);

  // flush drops both a same-cycle push and pop
  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;

  // single-word ops store HI as zero so no stale HI is ever visible
  always_comb begin
    wr_entry    = '0;
    wr_entry.op = op_in;
    wr_entry.lo = c_lo_in;
    wr_entry.hi = is_wide(op_in) ? c_hi_in : 32'h0;
  end

  z_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (tail_ptr),
    .wdata (wr_entry),
    .raddr (head_ptr),
    .rdata (head)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else if (flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        tail_ptr <= tail_ptr + PTR_ONE;
      end
      if (pop) begin
        head_ptr <= head_ptr + PTR_ONE;
      end
      unique case (1'b1)
        (push && !pop): count <= count + CNT_ONE;
        (pop && !push): count <= count - CNT_ONE;
        default: ;
      endcase
    end
  end

  // sel_hi outranks sel_lo; nothing driven when empty
  always_comb begin
    bus_out = 32'h0;
    if (out_valid) begin
      if (sel_hi) begin
        bus_out = head.hi;
      end else if (sel_lo) begin
        bus_out = head.lo;
      end
    end
  end

`ifdef Z_FLAGS_EN
  always_comb begin
    z_zero = 1'b0;
    z_neg  = 1'b0;
    if (out_valid) begin
      z_zero = ({head.hi, head.lo} == 64'h0);
      z_neg  = is_wide(head.op) ? head.hi[31] : head.lo[31];
    end
  end
`else
  logic unused_op;
  assign unused_op = ^head.op;
  assign z_zero    = 1'b0;
  assign z_neg     = 1'b0;
`endif

endmodule

// File: tb/tb_z_result_stage.sv
// Bench for z_result_stage: directed test-plan cases plus random
// traffic checked every cycle against a queue model.
module tb_z_result_stage;

  localparam int DEPTH = 2;
  localparam int CW = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          clr_n;
  logic [31:0]   c_lo_in, c_hi_in;
  logic [3:0]    op_in;
  logic          in_valid, in_ready, flush;
  logic          out_valid, out_ready;
  logic          sel_hi, sel_lo;
  logic [31:0]   bus_out;
  logic          z_zero, z_neg;
  logic [CW-1:0] count;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] hi;
    logic [31:0] lo;
  } ent_t;

  ent_t q[$];

  always #5 clk = ~clk;

  z_result_stage #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .c_lo_in   (c_lo_in),
    .c_hi_in   (c_hi_in),
    .op_in     (op_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sel_hi    (sel_hi),
    .sel_lo    (sel_lo),
    .bus_out   (bus_out),
    .z_zero    (z_zero),
    .z_neg     (z_neg),
    .count     (count)
  );

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, act, exp, $time);
    end
  endtask

  // model: results are a queue; MUL(10)/DIV(11) keep HI, others zero it
  always @(posedge clk) begin
    if (clr_n) begin
      if (flush) begin
        q.delete();
      end else begin
        bit room;
        ent_t e;
        room = (q.size() < DEPTH);
        if (q.size() > 0 && out_ready) void'(q.pop_front());
        if (in_valid && room) begin
          e.op = op_in;
          e.lo = c_lo_in;
          e.hi = (op_in == 4'd10 || op_in == 4'd11) ? c_hi_in : 32'h0;
          q.push_back(e);
        end
      end
    end
  end

  always @(negedge clr_n) q.delete();

  // compare process: every falling edge
  always @(negedge clk) begin
    logic [31:0] eb;
    logic ez, en;
    eb = 32'h0;
    ez = 1'b0;
    en = 1'b0;
    if (q.size() > 0) begin
      if (sel_hi) eb = q[0].hi;
      else if (sel_lo) eb = q[0].lo;
`ifdef Z_FLAGS_EN
      ez = ({q[0].hi, q[0].lo} == 64'h0);
      en = (q[0].op == 4'd10 || q[0].op == 4'd11) ?
           q[0].hi[31] : q[0].lo[31];
`endif
    end
    chk("count", 64'(count), 64'(q.size()));
    chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
    chk("in_ready", 64'(in_ready), 64'(q.size() < DEPTH));
    chk("bus_out", 64'(bus_out), 64'(eb));
    chk("z_zero", 64'(z_zero), 64'(ez));
    chk("z_neg", 64'(z_neg), 64'(en));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [31:0] hi,
                        input logic [31:0] lo, input logic [3:0] op);
    in_valid = v;
    c_hi_in  = hi;
    c_lo_in  = lo;
    op_in    = op;
  endtask

  initial begin
    clr_n = 1'b0;
    set_in(1'b0, 32'h0, 32'h0, 4'd4);
    flush = 0; out_ready = 0; sel_hi = 0; sel_lo = 0;
    #2;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_bus", 64'(bus_out), 64'd0);
    chk("rst_flags", 64'({z_zero, z_neg}), 64'd0);
    tick();
    clr_n = 1'b1;
    tick();

    // MUL keeps HI
    set_in(1'b1, 32'h1234, 32'h5, 4'd10);
    tick();
    in_valid = 0; sel_hi = 1;
    #1 chk("mul_valid", 64'(out_valid), 64'd1);
    chk("mul_hi", 64'(bus_out), 64'h1234);
    sel_hi = 0; sel_lo = 1;
    #1 chk("mul_lo", 64'(bus_out), 64'h5);
    out_ready = 1;
    tick();
    out_ready = 0;

    // single-word op clears HI
    set_in(1'b1, 32'hFFFF_FFFF, 32'h7, 4'd4);
    tick();
    in_valid = 0; sel_lo = 0; sel_hi = 1;
    #1 chk("and_hi", 64'(bus_out), 64'h0);
    sel_hi = 0; sel_lo = 1;
    #1 chk("and_lo", 64'(bus_out), 64'h7);
    out_ready = 1;
    tick();
    out_ready = 0;

    // fill past full
    set_in(1'b1, 32'h0, 32'hA1, 4'd6);
    tick();
    c_lo_in = 32'hA2;
    tick();
    chk("full_ready", 64'(in_ready), 64'd0);
    chk("full_count", 64'(count), 64'd2);
    c_lo_in = 32'hA3;
    tick();
    in_valid = 0;
    chk("full_count2", 64'(count), 64'd2);
    chk("full_head", 64'(bus_out), 64'hA1);
    out_ready = 1;
    tick();
    chk("pop1_count", 64'(count), 64'd1);
    chk("pop1_head", 64'(bus_out), 64'hA2);
    tick();
    chk("pop2_count", 64'(count), 64'd0);
    chk("pop2_bus", 64'(bus_out), 64'h0);
    out_ready = 0;

    // sustained push+pop at count=1
    set_in(1'b1, 32'h0, 32'h100, 4'd7);
    tick();
    out_ready = 1;
    for (int i = 1; i <= 10; i++) begin
      c_lo_in = 32'h100 + 32'(i);
      tick();
      chk("thru_count", 64'(count), 64'd1);
      chk("thru_head", 64'(bus_out), 64'(32'h100 + 32'(i)));
    end
    in_valid = 0;
    tick();
    out_ready = 0;

    // flush with simultaneous push
    set_in(1'b1, 32'h0, 32'hB1, 4'd5);
    tick();
    c_lo_in = 32'hB2;
    tick();
    flush = 1; c_lo_in = 32'hB3;
    tick();
    flush = 0; in_valid = 0;
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_bus", 64'(bus_out), 64'd0);

    // flags
    set_in(1'b1, 32'h0, 32'h0, 4'd5);
    tick();
    in_valid = 0;
`ifdef Z_FLAGS_EN
    chk("flag_zero", 64'(z_zero), 64'd1);
`else
    chk("flag_zero_off", 64'(z_zero), 64'd0);
`endif
    out_ready = 1;
    tick();
    out_ready = 0;
    set_in(1'b1, 32'h8000_0000, 32'h0, 4'd11);
    tick();
    in_valid = 0;
`ifdef Z_FLAGS_EN
    chk("flag_neg", 64'(z_neg), 64'd1);
    chk("flag_nz", 64'(z_zero), 64'd0);
`else
    chk("flag_neg_off", 64'(z_neg), 64'd0);
`endif

    // asynchronous reset mid-cycle
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    #2 clr_n = 1'b0;
    #1 chk("async_valid", 64'(out_valid), 64'd0);
    chk("async_count", 64'(count), 64'd0);
    tick();
    clr_n = 1'b1;
    tick();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] op;
      op = 4'($urandom_range(4, 11));
      set_in(1'($urandom_range(0, 3) != 0), $urandom(),
             ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom(), op);
      if ($urandom_range(0, 7) == 0) c_hi_in = 32'h0;
      out_ready = 1'($urandom_range(0, 2) != 0);
      flush = 1'($urandom_range(0, 40) == 0);
      sel_hi = 1'($urandom);
      sel_lo = 1'($urandom);
      tick();
    end
    set_in(1'b0, 32'h0, 32'h0, 4'd4);
    flush = 0; out_ready = 0;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
